// File: rtl/press_classifier.sv
// press_classifier: turns a debounced button level into short, long
// and auto-repeat event pulses plus a held level, off one shared timer.
module press_classifier #(
  parameter int LONG_PRESS_ns    = 100,
  parameter int REPEAT_PERIOD_ns = 60,
  parameter int CLK_PERIOD_ns    = 20
) (
  input  logic clk,
  input  logic reset_sync,
  input  logic btn,
  output logic short_press,
  output logic long_press,
  output logic repeat_press,
  output logic held
);

  localparam int LONG_CYCLES = LONG_PRESS_ns / CLK_PERIOD_ns;
  localparam int REPEAT_CYCLES = REPEAT_PERIOD_ns / CLK_PERIOD_ns;
  localparam bit REP_EN = (REPEAT_CYCLES > 0);
  localparam int MAX_CYCLES =
    (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES) + 1;

  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] LONG_LOAD = CW'(LONG_CYCLES - 1);
  // The long_press edge is not itself a repeat sample, so HELD
  // reloads a full period to space repeats REPEAT_CYCLES highs apart.
  localparam logic [CW-1:0] REP_LOAD = CW'(REPEAT_CYCLES);

  typedef enum logic [1:0] {
    WAIT_LOW,
    IDLE,
    PRESSED,
    HELD
  } state_t;

  state_t state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset_sync) begin
      state <= WAIT_LOW;
      cnt <= '0;
      short_press <= 1'b0;
      long_press <= 1'b0;
      repeat_press <= 1'b0;
      held <= 1'b0;
    end else begin
      short_press <= 1'b0;
      long_press <= 1'b0;
      repeat_press <= 1'b0;
      unique case (state)
        WAIT_LOW: begin
          if (!btn) state <= IDLE;
        end
        IDLE: begin
          if (btn) begin
            state <= PRESSED;
            cnt <= LONG_LOAD;
          end
        end
        PRESSED: begin
          if (!btn) begin
            state <= IDLE;
            short_press <= 1'b1;
          end else if (cnt == ONE) begin
            state <= HELD;
            long_press <= 1'b1;
            held <= 1'b1;
            cnt <= REP_LOAD;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        HELD: begin
          if (!btn) begin
            state <= IDLE;
            held <= 1'b0;
          end else if (REP_EN) begin
            if (cnt == ONE) begin
              repeat_press <= 1'b1;
              cnt <= REP_LOAD;
            end else begin
              cnt <= cnt - ONE;
            end
          end
        end
        default: state <= WAIT_LOW;
      endcase
    end
  end

endmodule

// File: tb/tb_press_classifier.sv
// tb_press_classifier: directed and random button patterns against a
// run-length model of the press rules, on a repeat and a no-repeat DUT.
module tb_press_classifier;

  localparam int L = 100 / 20;
  localparam int RA = 60 / 20;

  logic clk = 1'b0;
  logic reset_sync = 1'b1;
  logic btn = 1'b0;
  logic sh_a, lg_a, rp_a, hd_a;
  logic sh_b, lg_b, rp_b, hd_b;

  int total = 0;
  int bad = 0;

  bit armed = 1'b0;
  int run = 0;
  logic [3:0] exp_a = '0;
  logic [3:0] exp_b = '0;

  always #10 clk = ~clk;

  press_classifier dut_a (
    .clk(clk), .reset_sync(reset_sync), .btn(btn),
    .short_press(sh_a), .long_press(lg_a),
    .repeat_press(rp_a), .held(hd_a)
  );

  press_classifier #(.REPEAT_PERIOD_ns(0)) dut_b (
    .clk(clk), .reset_sync(reset_sync), .btn(btn),
    .short_press(sh_b), .long_press(lg_b),
    .repeat_press(rp_b), .held(hd_b)
  );

  wire [3:0] obs_a = {sh_a, lg_a, rp_a, hd_a};
  wire [3:0] obs_b = {sh_b, lg_b, rp_b, hd_b};

  // One edge: drive, clock, advance the model, settle.
  task automatic step(input logic b, input logic r);
    bit lg, rp, hd, sh;
    btn = b;
    reset_sync = r;
    @(posedge clk);
    if (r) begin
      armed = 1'b0;
      run = 0;
      exp_a = '0;
      exp_b = '0;
    end else if (!armed) begin
      if (!b) armed = 1'b1;
      exp_a = '0;
      exp_b = '0;
    end else if (b) begin
      run++;
      lg = (run == L);
      rp = (run > L) && ((run - L) % RA == 0);
      hd = (run >= L);
      exp_a = {1'b0, lg, rp, hd};
      exp_b = {1'b0, lg, 1'b0, hd};
    end else begin
      sh = (run >= 1) && (run < L);
      exp_a = {sh, 3'b000};
      exp_b = {sh, 3'b000};
      run = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    total++;
    if (obs_a !== 4'b0000 || obs_b !== 4'b0000) begin
      bad++;
      $display("FAIL reset a=%b b=%b want 0000", obs_a, obs_b);
    end
  endtask

  task automatic test_short();
    logic q[$];
    int ns = 0, nl = 0;
    q = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    foreach (q[i]) begin
      step(q[i], 1'b0);
      ns += int'(sh_a);
      nl += int'(lg_a | hd_a | rp_a);
      total++;
      if (obs_a !== exp_a || obs_b !== exp_b) begin
        bad++;
        $display("FAIL short e%0d a=%b/%b b=%b/%b",
                 i, obs_a, exp_a, obs_b, exp_b);
      end
      if (i == 5) begin
        total++;
        if (sh_a !== 1'b1) begin
          bad++;
          $display("FAIL short_pulse got %b want 1", sh_a);
        end
      end
    end
    total++;
    if (ns != 1 || nl != 0) begin
      bad++;
      $display("FAIL short_count short=%0d other=%0d want 1/0", ns, nl);
    end
  endtask

  task automatic test_long();
    logic q[$];
    int ns = 0, nl = 0;
    q = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    foreach (q[i]) begin
      step(q[i], 1'b0);
      ns += int'(sh_a);
      nl += int'(lg_a);
      total++;
      if (obs_a !== exp_a || obs_b !== exp_b) begin
        bad++;
        $display("FAIL long e%0d a=%b/%b b=%b/%b",
                 i, obs_a, exp_a, obs_b, exp_b);
      end
      if (i == 4 || i == 5) begin
        total++;
        if (hd_a !== (i == 4) || lg_a !== (i == 4)) begin
          bad++;
          $display("FAIL long_held e%0d held=%b long=%b", i, hd_a, lg_a);
        end
      end
    end
    total++;
    if (ns != 0 || nl != 1) begin
      bad++;
      $display("FAIL long_count short=%0d long=%0d want 0/1", ns, nl);
    end
  endtask

  task automatic test_repeat();
    int nr = 0, nl = 0, nh = 0;
    for (int i = 0; i < 16; i++) begin
      step(i < 14, 1'b0);
      nr += int'(rp_a);
      nl += int'(lg_a);
      nh += int'(hd_a);
      total++;
      if (obs_a !== exp_a || obs_b !== exp_b) begin
        bad++;
        $display("FAIL repeat e%0d a=%b/%b b=%b/%b",
                 i, obs_a, exp_a, obs_b, exp_b);
      end
    end
    total++;
    if (nr != 3 || nl != 1 || nh != 10) begin
      bad++;
      $display("FAIL repeat_count rep=%0d long=%0d held=%0d want 3/1/10",
               nr, nl, nh);
    end
  endtask

  task automatic test_back_to_back();
    logic q[$];
    int ns = 0, nl = 0;
    q = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
         1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    foreach (q[i]) begin
      step(q[i], 1'b0);
      ns += int'(sh_a);
      nl += int'(lg_a);
      total++;
      if (obs_a !== exp_a || obs_b !== exp_b) begin
        bad++;
        $display("FAIL b2b e%0d a=%b/%b b=%b/%b",
                 i, obs_a, exp_a, obs_b, exp_b);
      end
      if (i == 9) begin
        total++;
        if (lg_a !== 1'b1) begin
          bad++;
          $display("FAIL b2b_restart long=%b want 1", lg_a);
        end
      end
    end
    total++;
    if (ns != 3 || nl != 1) begin
      bad++;
      $display("FAIL b2b_count short=%0d long=%0d want 3/1", ns, nl);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] q[$];
    int ns = 0, nany = 0;
    q = {2'b01, 2'b01, 2'b11};
    for (int i = 0; i < 10; i++) q.push_back(2'b01);
    q.push_back(2'b00);
    q.push_back(2'b01);
    q.push_back(2'b01);
    q.push_back(2'b00);
    q.push_back(2'b00);
    foreach (q[i]) begin
      step(q[i][0], q[i][1]);
      if (i >= 2) begin
        ns += int'(sh_a);
        nany += int'(lg_a | rp_a | hd_a);
      end
      total++;
      if (obs_a !== exp_a || obs_b !== exp_b) begin
        bad++;
        $display("FAIL reset_mid e%0d a=%b/%b b=%b/%b",
                 i, obs_a, exp_a, obs_b, exp_b);
      end
    end
    total++;
    if (ns != 1 || nany != 0) begin
      bad++;
      $display("FAIL reset_mid_count short=%0d other=%0d want 1/0", ns, nany);
    end
  endtask

  task automatic test_no_repeat();
    int rb = 0, lb = 0, ra = 0;
    for (int i = 0; i < 22; i++) begin
      step(i < 20, 1'b0);
      rb += int'(rp_b);
      lb += int'(lg_b);
      ra += int'(rp_a);
      if (i == 19) begin
        total++;
        if (hd_b !== 1'b1) begin
          bad++;
          $display("FAIL norep_held got %b want 1", hd_b);
        end
      end
      total++;
      if (obs_a !== exp_a || obs_b !== exp_b) begin
        bad++;
        $display("FAIL norep e%0d a=%b/%b b=%b/%b",
                 i, obs_a, exp_a, obs_b, exp_b);
      end
    end
    total++;
    if (rb != 0 || lb != 1 || ra != 5) begin
      bad++;
      $display("FAIL norep_count repb=%0d longb=%0d repa=%0d want 0/1/5",
               rb, lb, ra);
    end
  endtask

  task automatic test_random();
    logic b = 1'b0;
    int left = 0;
    logic r;
    for (int i = 0; i < 600; i++) begin
      if (left == 0) begin
        b = ~b;
        left = b ? int'($urandom_range(1, 18)) : int'($urandom_range(1, 4));
      end
      left--;
      r = ($urandom_range(0, 63) == 0);
      step(b, r);
      total++;
      if (obs_a !== exp_a || obs_b !== exp_b) begin
        bad++;
        $display("FAIL random e%0d a=%b/%b b=%b/%b",
                 i, obs_a, exp_a, obs_b, exp_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_repeat();
    test_back_to_back();
    test_reset_mid();
    test_no_repeat();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
